// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the risc_core slice.
//   - op_e     : 4-bit opcode encoding
//   - state_e  : fetch/decode/execute FSM states
//   - instruction word width and field bit positions
//   - small opcode-class helpers used by the core
package risc_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 8;
    localparam int RS_HI   = 7;
    localparam int RS_LO   = 4;
    localparam int RT_HI   = 3;
    localparam int RT_LO   = 0;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_NOT  = 4'h6,
        OP_SHL  = 4'h7,
        OP_SHR  = 4'h8,
        OP_LDI  = 4'h9,
        OP_LD   = 4'hA,
        OP_ST   = 4'hB,
        OP_JMP  = 4'hC,
        OP_BEQZ = 4'hD,
        OP_OUT  = 4'hE,
        OP_HALT = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    // Ops 1..8 are the ALU ops that update {N,C,Z}.
    function automatic logic is_alu(input op_e o);
        return (o inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR});
    endfunction

    // Ops 1..A write rd in WB.
    function automatic logic writes_rd(input op_e o);
        return is_alu(o) || (o == OP_LDI) || (o == OP_LD);
    endfunction

endpackage

// File: rtl/risc_regfile.sv
// risc_regfile: NREGS x DATA_W register file.
//   clk, rst (async active-low clear to 0)
//   we/waddr/wdata      : single write port, written on rising clk
//   raddr_a/rdata_a     : combinational read port A
//   raddr_b/rdata_b     : combinational read port B
//   raddr_d/rdata_d     : extra read port for the debug display
//                         (only when RISC_CORE_DBG_EN is defined)
module risc_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int RW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [RW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [RW-1:0]     raddr_b,
`ifdef RISC_CORE_DBG_EN
    input  logic [RW-1:0]     raddr_d,
    output logic [DATA_W-1:0] rdata_d,
`endif
    output logic [DATA_W-1:0] rdata_b
);

    logic [NREGS-1:0][DATA_W-1:0] regs;

    // One flop row per register; each row only listens to its own decode.
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                regs[r] <= '0;
            else if (we && (waddr == RW'(r)))
                regs[r] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];
`ifdef RISC_CORE_DBG_EN
    assign rdata_d = regs[raddr_d];
`endif

endmodule

// File: rtl/risc_core.sv
// risc_core: multi-cycle RISC core (FETCH/DECODE/EXEC/[MEM]/WB).
// Ports:
//   clk, rst (async active-low)
//   run (level, free-run), step (pulse, one instruction from IDLE)
//   imem_addr/imem_data    : sync program ROM, 1-cycle read latency
//   dmem_addr/dmem_we/dmem_wdata/dmem_rdata : sync data RAM, 1-cycle read
//   out_port/out_valid     : OUT result and its one-cycle strobe
//   pc, flags {N,C,Z}, halted, busy : status
// Optional build macro RISC_CORE_DBG_EN adds dbg_sel/dbg_data, a
// combinational register peek for the 7-segment display.
module risc_core
    import risc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    parameter int PC_W   = 4,
    parameter int ADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  dmem_addr,
    output logic               dmem_we,
    output logic [DATA_W-1:0]  dmem_wdata,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [DATA_W-1:0]  out_port,
    output logic               out_valid,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         flags,
`ifdef RISC_CORE_DBG_EN
    input  logic [3:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
`endif
    output logic               halted,
    output logic               busy
);

    localparam int RW = $clog2(NREGS);

    // Register fields are 4 bits wide; fold them into the actual file size.
    function automatic logic [RW-1:0] ridx(input logic [3:0] f);
        return RW'(32'(f) % NREGS);
    endfunction

    state_e              state;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   opa, opb, res;
    logic [DATA_W-1:0]   rdata_a, rdata_b, imm;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic [DATA_W:0]     wide;
    op_e                 op, dec_op;
    logic                rf_we;

    assign op        = op_e'(ir[OP_HI:OP_LO]);
    assign dec_op    = op_e'(imem_data[OP_HI:OP_LO]);
    assign imm       = DATA_W'(ir[IMM_HI:IMM_LO]);
    assign imem_addr = pc;
    assign rf_we     = (state == S_WB) && writes_rd(op);

    // Operands are read with the fields of the incoming ROM word so they
    // can be latched in the same DECODE cycle as the instruction.
    risc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .RW(RW)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (ridx(ir[RD_HI:RD_LO])),
        .wdata   (res),
        .raddr_a (ridx(imem_data[RS_HI:RS_LO])),
        .rdata_a (rdata_a),
        .raddr_b (ridx(imem_data[RT_HI:RT_LO])),
`ifdef RISC_CORE_DBG_EN
        .raddr_d (ridx(dbg_sel)),
        .rdata_d (dbg_data),
`endif
        .rdata_b (rdata_b)
    );

    // ALU; the default result is the immediate so LDI flows through unchanged.
    always_comb begin
        alu_res = imm;
        alu_c   = 1'b0;
        wide    = '0;
        case (op)
            OP_ADD: begin
                wide    = {1'b0, opa} + {1'b0, opb};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            OP_SUB: begin
                // Top bit of the widened difference is the borrow.
                wide    = {1'b0, opa} - {1'b0, opb};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            OP_XOR: alu_res = opa ^ opb;
            OP_NOT: alu_res = ~opa;
            OP_SHL: begin
                alu_res = {opa[DATA_W-2:0], 1'b0};
                alu_c   = opa[DATA_W-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, opa[DATA_W-1:1]};
                alu_c   = opa[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ir         <= '0;
            opa        <= '0;
            opb        <= '0;
            res        <= '0;
            pc         <= '0;
            flags      <= '0;
            dmem_addr  <= '0;
            dmem_we    <= 1'b0;
            dmem_wdata <= '0;
            out_port   <= '0;
            out_valid  <= 1'b0;
            halted     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dmem_we   <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                S_IDLE: if (run || step) begin
                    state <= S_FETCH;
                    busy  <= 1'b1;
                end
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    ir  <= imem_data;
                    opa <= rdata_a;
                    opb <= rdata_b;
                    // Registered here so the RAM sees address/strobe during EXEC.
                    if (dec_op == OP_LD || dec_op == OP_ST)
                        dmem_addr <= rdata_a[ADDR_W-1:0];
                    if (dec_op == OP_ST) begin
                        dmem_we    <= 1'b1;
                        dmem_wdata <= rdata_b;
                    end
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res <= alu_res;
                    if (is_alu(op))
                        flags <= {alu_res[DATA_W-1], alu_c, alu_res == '0};
                    if (op == OP_LD)
                        state <= S_MEM;
                    else if (op == OP_HALT) begin
                        halted <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_HALT;
                    end else
                        state <= S_WB;
                end
                S_MEM: begin
                    res   <= dmem_rdata;
                    state <= S_WB;
                end
                S_WB: begin
                    if (op == OP_JMP || (op == OP_BEQZ && opa == '0))
                        pc <= PC_W'(ir[IMM_HI:IMM_LO]);
                    else
                        pc <= pc + PC_W'(1);
                    if (op == OP_OUT) begin
                        out_port  <= opa;
                        out_valid <= 1'b1;
                    end
                    if (run)
                        state <= S_FETCH;
                    else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_core.sv
module tb_risc_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  imem_addr;
    logic [15:0] imem_data;
    logic [3:0]  dmem_addr;
    logic        dmem_we;
    logic [7:0]  dmem_wdata;
    logic [7:0]  dmem_rdata;
    logic [7:0]  out_port;
    logic        out_valid;
    logic [3:0]  pc;
    logic [2:0]  flags;
    logic        halted;
    logic        busy;

    logic [15:0] rom [16];
    logic [7:0]  ram [16];
    logic [7:0]  sbq [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    risc_core #(.DATA_W(8), .NREGS(4), .PC_W(4), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_addr  (dmem_addr),
        .dmem_we    (dmem_we),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .out_port   (out_port),
        .out_valid  (out_valid),
        .pc         (pc),
        .flags      (flags),
        .halted     (halted),
        .busy       (busy)
    );

    // Synchronous ROM/RAM with one-cycle read latency.
    always @(posedge clk) begin
        imem_data  <= rom[imem_addr];
        if (dmem_we) ram[dmem_addr] <= dmem_wdata;
        dmem_rdata <= ram[dmem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n cycles, sampling on the falling edge; every out_valid
    // cycle retires one expected value from the scoreboard.
    task automatic cyc(input int n);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_valid) begin
                if (sbq.size() == 0) chk("sb_unexpected_out", {out_valid, out_port}, 9'h0);
                else begin
                    e = sbq.pop_front();
                    chk("sb_out_port", out_port, e);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; run = 1'b0; step = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    endtask

    // One step pulse; lat = busy cycles, plus a capture of any RAM write.
    task automatic step_one(input bit dbl, output int lat, output int we_cnt,
                            output logic [3:0] we_addr, output logic [7:0] we_data);
        lat = 0; we_cnt = 0; we_addr = '0; we_data = '0;
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            lat++;
            if (dmem_we) begin
                we_cnt++;
                we_addr = dmem_addr;
                we_data = dmem_wdata;
            end
            step = (dbl && i == 1);
            cyc(1);
        end
        step = 1'b0;
        chk("step_done_busy", busy, 1'b0);
    endtask

    task automatic wait_halt(input int max);
        for (int i = 0; i < max; i++) begin
            if (halted) break;
            cyc(1);
        end
        chk("halt_reached", halted, 1'b1);
    endtask

    initial begin
        int lat, wc;
        logic [3:0] wa;
        logic [7:0] wd;

        clear_rom();
        // Reset state
        cyc(1);
        chk("reset_outputs", {imem_addr, dmem_addr, dmem_we, dmem_wdata, out_port,
                              out_valid, pc, flags, halted, busy}, 64'h0);
        rst = 1'b1;
        cyc(1);

        // Free-run: 5 + 3 -> OUT 8, flags clear, then HALT freezes pc
        clear_rom();
        rom[0] = 16'h9105; rom[1] = 16'h9203; rom[2] = 16'h1012;
        rom[3] = 16'hE000; rom[4] = 16'hF000;
        do_reset();
        sbq.push_back(8'h08);
        run = 1'b1;
        wait_halt(100);
        chk("add_flags", flags, 3'b000);
        chk("halt_busy", busy, 1'b0);
        chk("halt_pc", pc, 4'd4);
        cyc(5);
        chk("halt_pc_frozen", pc, 4'd4);
        chk("halt_sticky", halted, 1'b1);
        run = 1'b0;
        chk("sb_drained_1", sbq.size(), 0);

        // Step mode: carry/zero on ADD, borrow on SUB
        clear_rom();
        rom[0] = 16'h91FF; rom[1] = 16'h9201; rom[2] = 16'h1312; rom[3] = 16'hE030;
        rom[4] = 16'h2321; rom[5] = 16'hE030; rom[6] = 16'hF000;
        do_reset();
        step_one(0, lat, wc, wa, wd);
        chk("ldi_latency", lat, 4);
        step_one(0, lat, wc, wa, wd);
        step_one(0, lat, wc, wa, wd);
        chk("add_wrap_latency", lat, 4);
        chk("add_wrap_flags", flags, 3'b011);
        sbq.push_back(8'h00);
        step_one(0, lat, wc, wa, wd);
        chk("out_keeps_flags", flags, 3'b011);
        step_one(0, lat, wc, wa, wd);
        chk("sub_borrow_flags", flags, 3'b010);
        sbq.push_back(8'h02);
        step_one(0, lat, wc, wa, wd);
        step_one(0, lat, wc, wa, wd);
        chk("halt_latency", lat, 3);
        chk("halt_after_step", halted, 1'b1);
        chk("sb_drained_2", sbq.size(), 0);

        // Store then load back through RAM
        clear_rom();
        rom[0] = 16'h91A5; rom[1] = 16'h9207; rom[2] = 16'hB021;
        rom[3] = 16'hA320; rom[4] = 16'hE030; rom[5] = 16'hF000;
        do_reset();
        step_one(0, lat, wc, wa, wd);
        step_one(0, lat, wc, wa, wd);
        step_one(0, lat, wc, wa, wd);
        chk("st_latency", lat, 4);
        chk("st_we_cycles", wc, 1);
        chk("st_addr", wa, 4'd7);
        chk("st_data", wd, 8'hA5);
        chk("ram_contents", ram[7], 8'hA5);
        step_one(0, lat, wc, wa, wd);
        chk("ld_latency", lat, 5);
        chk("ld_no_write", wc, 0);
        sbq.push_back(8'hA5);
        step_one(0, lat, wc, wa, wd);
        chk("sb_drained_3", sbq.size(), 0);

        // Branches, PC wrap, and a step pulse while busy
        clear_rom();
        rom[0] = 16'hD006; rom[6] = 16'h9101; rom[7] = 16'hD012; rom[8] = 16'hC00F;
        do_reset();
        step_one(1, lat, wc, wa, wd);
        chk("beqz_taken_pc", pc, 4'd6);
        cyc(3);
        chk("busy_step_ignored", {busy, pc}, {1'b0, 4'd6});
        step_one(0, lat, wc, wa, wd);
        chk("ldi_pc", pc, 4'd7);
        step_one(0, lat, wc, wa, wd);
        chk("beqz_not_taken_pc", pc, 4'd8);
        step_one(0, lat, wc, wa, wd);
        chk("jmp_pc", pc, 4'd15);
        step_one(0, lat, wc, wa, wd);
        chk("pc_wrap", pc, 4'd0);

        // run dropped mid-instruction: current one completes, then IDLE
        clear_rom();
        do_reset();
        run = 1'b1;
        cyc(6);
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            cyc(1);
        end
        chk("run_drop_idle", busy, 1'b0);
        chk("run_drop_pc", pc, 4'd2);
        cyc(3);
        chk("run_drop_stays", {busy, pc}, {1'b0, 4'd2});

        // Reset asserted in the EXEC cycle of ADD r0
        clear_rom();
        rom[0] = 16'h9105; rom[1] = 16'h9203; rom[2] = 16'h1012;
        do_reset();
        step_one(0, lat, wc, wa, wd);
        step_one(0, lat, wc, wa, wd);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        cyc(2);
        chk("pre_reset_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        chk("reset_mid_exec_outputs", {imem_addr, dmem_addr, dmem_we, dmem_wdata, out_port,
                                       out_valid, pc, flags, halted, busy}, 64'h0);
        clear_rom();
        rom[0] = 16'hE000; rom[1] = 16'hF000;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        sbq.push_back(8'h00);
        run = 1'b1;
        wait_halt(50);
        run = 1'b0;
        chk("reset_r0_pc", pc, 4'd1);
        chk("sb_drained_4", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risc_core.md
# risc_core

Parametrised multi-cycle RISC processor core with an internal register file, a load/store data path and a fetch/decode/execute/writeback state machine. It is the next generation of the board-level 4-bit processor. Instructions execute only from registers, never directly from memory; memory is reached through explicit LD/ST. The core sits between the board top level (switches, keys, LEDs, 7-segment driver) and external synchronous program ROM and data RAM.

## Interface
Parameters:
- DATA_W, 8, register/ALU/data width (4..16)
- NREGS, 4, register count (2..16)
- PC_W, 4, program counter width; program space 2^PC_W words
- ADDR_W, 4, data RAM address width (ADDR_W <= DATA_W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = free-running execution
- step  in  1  one-cycle pulse; runs exactly one instruction from IDLE
- imem_addr  out  PC_W  program ROM address
- imem_data  in  16  ROM word; valid one cycle after imem_addr
- dmem_addr  out  ADDR_W  data RAM address
- dmem_we  out  1  data RAM write strobe, one cycle
- dmem_wdata  out  DATA_W  data RAM write data
- dmem_rdata  in  DATA_W  RAM read data; valid one cycle after dmem_addr
- out_port  out  DATA_W  value written by OUT
- out_valid  out  1  one-cycle pulse when out_port updates
- pc  out  PC_W  current PC
- flags  out  3  {N, C, Z}
- halted  out  1  core stopped by HALT
- busy  out  1  high in any state except IDLE and HALT

Every output resets to 0.

## Operation
- Instruction word: op[15:12], rd[11:8], rs[7:4], rt[3:0]; imm = [7:0], zero-extended or truncated to DATA_W. Register indices are taken modulo NREGS.
- Opcodes:
  - 0 NOP
  - 1 ADD rd=rs+rt
  - 2 SUB rd=rs-rt
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT rd=~rs
  - 7 SHL rd=rs<<1
  - 8 SHR rd=rs>>1 (logical)
  - 9 LDI rd=imm
  - A LD rd=mem[rs]
  - B ST mem[rs]=rt
  - C JMP pc=imm
  - D BEQZ if rs==0 pc=imm
  - E OUT out_port=rs
  - F HALT
- Arithmetic is modulo 2^DATA_W.
  - ADD: C = carry out.
  - SUB: C = borrow, N = result MSB.
  - SHL/SHR: C = shifted-out bit.
  - Z = (result == 0).
  - Flags update only on ops 1..8; all other ops leave flags unchanged.
- ST and LD addresses are rs[ADDR_W-1:0].
- FSM states: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
  - IDLE: go to FETCH if run or step; otherwise stay.
  - FETCH: drive imem_addr=pc; go to DECODE.
  - DECODE: latch imem_data into the instruction register and read operands; go to EXEC.
  - EXEC: run the ALU or branch decision. For LD, drive dmem_addr and go to MEM. For ST, assert dmem_we with address and data, then go to WB. For HALT, set halted and go to HALT. All others go to WB.
  - MEM: capture dmem_rdata; go to WB.
  - WB: write rd for ops 1..A; update pc (target or pc+1); pulse out_valid for OUT. Then go to FETCH if run, else IDLE.
  - HALT: absorbing state; only rst exits it.
- PC wraps from 2^PC_W-1 to 0.
- step while busy, or while run=1, is ignored.
- run falling mid-instruction: the current instruction completes, then the FSM returns to IDLE.
- Reset mid-instruction: state goes to IDLE, registers and all outputs clear, and no partial write is committed.

## Timing
- Latency: 4 cycles for ALU, LDI, ST, JMP, BEQZ, OUT and NOP; 5 cycles for LD; HALT enters the HALT state 3 cycles after FETCH.
- ROM and RAM read latency is exactly one cycle; the core does not tolerate wait states.
- Register file: combinational read, write on the WB edge; no forwarding is required (multi-cycle).
- dmem_we is high for exactly the EXEC cycle of ST.

## Configuration
- RISC_CORE_DBG_EN defined: adds ports dbg_sel (in, 4) and dbg_data (out, DATA_W). dbg_data combinationally shows register dbg_sel mod NREGS, for the 7-segment display.
- Not defined: those ports and their logic are absent. All other behaviour is identical.

## Structure
- Package risc_pkg holds:
  - the opcode enum
  - the FSM state enum
  - instruction field bit positions and the 16-bit word width
- Sub-module risc_regfile: NREGS x DATA_W, asynchronous active-low clear to 0, two combinational read ports, one write port.

## Test plan
- LDI r1,5; LDI r2,3; ADD r0,r1,r2; OUT r0 -> out_port=8 with out_valid one cycle, flags=000.
- DATA_W=8: LDI r1,0xFF; LDI r2,1; ADD r3,r1,r2 -> r3=0, Z=1, C=1. Then SUB r3,r2,r1 -> 0x02, C=1, N=0.
- LDI r1,0xA5; LDI r2,7; ST [r2],r1; LD r3,[r2]; OUT r3 -> dmem_we single cycle at addr 7; out_port=0xA5; LD takes 5 cycles.
- BEQZ r0 (r0=0) to 6 -> pc=6. JMP from pc=15 with PC_W=4 and no jump -> pc wraps to 0.
- run=0, step pulsed once -> exactly one instruction retires and busy falls. A second step while busy is ignored.
- HALT -> halted=1, busy=0, pc frozen. Assert rst mid-EXEC of an ADD -> destination register stays 0 and all outputs read 0.
